// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I controller: opcodes, funct3 values, ALU
// operations, immediate selects, result selects and the E-stage bundle.
package riscv_pkg;

  // Base opcodes (InstrD[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // funct3 for OP / OP-IMM
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // ALU operations
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // Immediate format selects
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Writeback result selects
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Control bundle carried from decode into the E stage
  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic       jump;
    logic       jalr;
    logic       branch;
    logic       aluSrc;
    logic       aluSrcA;
    logic [1:0] resultSrc;
    logic [3:0] aluControl;
    logic [2:0] funct3;
    logic       illegal;
  } ctrl_e_t;

  // A bubble is the all-zero bundle
  localparam ctrl_e_t CTRL_BUBBLE = '0;

  // ALU op for OP / OP-IMM; only register-register ops may select SUB
  function automatic logic [3:0] aluFromFunct3(input logic [2:0] f3,
                                               input logic       alt,
                                               input logic       isRegOp);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      F3_ADD:  op = (isRegOp && alt) ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/main_decoder_ext.sv
// Combinational RV32I main decoder: opcode/funct3/funct7 to the E-stage
// control bundle plus the immediate select used in decode.
module main_decoder_ext
  import riscv_pkg::*;
#(
  parameter int TRAP_ILLEGAL = 1
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output ctrl_e_t    ctrl,
  output logic [2:0] immSrc
);

  logic illegal;
  logic alt;

  assign alt = funct7[5];

  // Decode one instruction; illegal encodings collapse to a bubble with the trap flag
  always_comb begin
    ctrl        = CTRL_BUBBLE;
    ctrl.funct3 = funct3;
    immSrc      = IMM_I;
    illegal     = 1'b0;
    case (opcode)
      OP_LOAD: begin
        ctrl.regWrite   = 1'b1;
        ctrl.aluSrc     = 1'b1;
        ctrl.resultSrc  = RES_MEM;
        ctrl.aluControl = ALU_ADD;
        immSrc          = IMM_I;
        illegal         = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OP_STORE: begin
        ctrl.memWrite   = 1'b1;
        ctrl.aluSrc     = 1'b1;
        ctrl.aluControl = ALU_ADD;
        immSrc          = IMM_S;
        illegal         = funct3[2] || (funct3 == 3'b011);
      end
      OP_RTYPE: begin
        ctrl.regWrite   = 1'b1;
        ctrl.aluControl = aluFromFunct3(funct3, alt, 1'b1);
        illegal         = !((funct7 == 7'h00) || (funct7 == 7'h20));
      end
      OP_ITYPE: begin
        ctrl.regWrite   = 1'b1;
        ctrl.aluSrc     = 1'b1;
        ctrl.aluControl = aluFromFunct3(funct3, alt, 1'b0);
        immSrc          = IMM_I;
      end
      OP_BRANCH: begin
        ctrl.branch = 1'b1;
        immSrc      = IMM_B;
        case (funct3[2:1])
          2'b00:   ctrl.aluControl = ALU_SUB;
          2'b10:   ctrl.aluControl = ALU_SLT;
          2'b11:   ctrl.aluControl = ALU_SLTU;
          default: ctrl.aluControl = ALU_ADD;
        endcase
        illegal = (funct3[2:1] == 2'b01);
      end
      OP_JAL: begin
        ctrl.regWrite   = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.aluSrc     = 1'b1;
        ctrl.resultSrc  = RES_PC4;
        ctrl.aluControl = ALU_ADD;
        immSrc          = IMM_J;
      end
      OP_JALR: begin
        ctrl.regWrite   = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.jalr       = 1'b1;
        ctrl.aluSrc     = 1'b1;
        ctrl.resultSrc  = RES_PC4;
        ctrl.aluControl = ALU_ADD;
        immSrc          = IMM_I;
      end
      OP_LUI: begin
        ctrl.regWrite   = 1'b1;
        ctrl.aluSrc     = 1'b1;
        ctrl.aluControl = ALU_PASSB;
        immSrc          = IMM_U;
      end
      OP_AUIPC: begin
        ctrl.regWrite   = 1'b1;
        ctrl.aluSrc     = 1'b1;
        ctrl.aluSrcA    = 1'b1;
        ctrl.aluControl = ALU_ADD;
        immSrc          = IMM_U;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      ctrl         = CTRL_BUBBLE;
      ctrl.illegal = (TRAP_ILLEGAL != 0);
      immSrc       = IMM_I;
    end
  end

endmodule

// File: rtl/controller_pipe.sv
// Pipelined controller: decodes in D and carries controls through E, M, W.
// E can stall or flush; while E stalls, M takes a bubble so the held
// instruction is not issued to memory twice. W never stalls.
module controller_pipe
  import riscv_pkg::*;
#(
  parameter int ALU_CTRL_W   = 4,
  parameter int IMM_SRC_W    = 3,
  parameter int TRAP_ILLEGAL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           InstrD,
  input  logic                  StallE,
  input  logic                  FlushE,
  input  logic                  FlushM,
  input  logic                  BranchTakenE,
  output logic [IMM_SRC_W-1:0]  ImmSrcD,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  JumpE,
  output logic                  JalrE,
  output logic                  BranchE,
  output logic                  ALUSrcE,
  output logic                  ALUSrcAE,
  output logic [1:0]            ResultSrcE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic [2:0]            funct3E,
  output logic                  IllegalE,
  output logic                  PCSrcE,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic [1:0]            ResultSrcM,
  output logic [2:0]            funct3M,
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcW
);

  ctrl_e_t    ctrlD;
  ctrl_e_t    ctrlE;
  logic [2:0] immSrcDec;
  logic       bubbleM;
  logic       unusedInstrBits;

  // Register/immediate fields are consumed by the datapath, not here
  assign unusedInstrBits = ^{InstrD[24:15], InstrD[11:7]};

  main_decoder_ext #(
    .TRAP_ILLEGAL(TRAP_ILLEGAL)
  ) uDecoder (
    .opcode(InstrD[6:0]),
    .funct3(InstrD[14:12]),
    .funct7(InstrD[31:25]),
    .ctrl  (ctrlD),
    .immSrc(immSrcDec)
  );

  assign ImmSrcD = IMM_SRC_W'(immSrcDec);

  // E register: reset and flush beat stall
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      ctrlE <= CTRL_BUBBLE;
    end else if (!StallE) begin
      ctrlE <= ctrlD;
    end
  end

  // A held E instruction must not also advance into M
  assign bubbleM = reset || FlushM || (StallE && !FlushE);

  // M register: takes E contents or a bubble
  always_ff @(posedge clk) begin
    if (bubbleM) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 2'b00;
      funct3M    <= 3'b000;
    end else begin
      RegWriteM  <= ctrlE.regWrite;
      MemWriteM  <= ctrlE.memWrite;
      ResultSrcM <= ctrlE.resultSrc;
      funct3M    <= ctrlE.funct3;
    end
  end

  // W register: free-running copy of M, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
    end else begin
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
    end
  end

  assign RegWriteE   = ctrlE.regWrite;
  assign MemWriteE   = ctrlE.memWrite;
  assign JumpE       = ctrlE.jump;
  assign JalrE       = ctrlE.jalr;
  assign BranchE     = ctrlE.branch;
  assign ALUSrcE     = ctrlE.aluSrc;
  assign ALUSrcAE    = ctrlE.aluSrcA;
  assign ResultSrcE  = ctrlE.resultSrc;
  assign ALUControlE = ALU_CTRL_W'(ctrlE.aluControl);
  assign funct3E     = ctrlE.funct3;
  assign IllegalE    = ctrlE.illegal;
  assign PCSrcE      = ctrlE.jump | (ctrlE.branch & BranchTakenE);

endmodule

// File: tb/tb_controller_pipe.sv
// Directed and randomized checks of controller_pipe: decode fields in E,
// stage latency through M and W, stall/flush/reset behaviour, branch/jump
// redirect and illegal-instruction trapping.
module tb_controller_pipe;
  import riscv_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic        rw;
    logic        mw;
    logic        aluSrc;
    logic        aluSrcA;
    logic [1:0]  res;
    logic [3:0]  alu;
    logic        chkImm;
    logic [2:0]  imm;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrD;
  logic        StallE, FlushE, FlushM, BranchTakenE;

  logic [2:0] ImmSrcD;
  logic       RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE, ALUSrcAE;
  logic [1:0] ResultSrcE;
  logic [3:0] ALUControlE;
  logic [2:0] funct3E;
  logic       IllegalE, PCSrcE, RegWriteM, MemWriteM;
  logic [1:0] ResultSrcM;
  logic [2:0] funct3M;
  logic       RegWriteW;
  logic [1:0] ResultSrcW;

  logic [2:0] zImmSrcD;
  logic       zRegWriteE, zMemWriteE, zJumpE, zJalrE, zBranchE, zALUSrcE, zALUSrcAE;
  logic [1:0] zResultSrcE;
  logic [3:0] zALUControlE;
  logic [2:0] zfunct3E;
  logic       zIllegalE, zPCSrcE, zRegWriteM, zMemWriteM;
  logic [1:0] zResultSrcM;
  logic [2:0] zfunct3M;
  logic       zRegWriteW;
  logic [1:0] zResultSrcW;

  int         cmpCnt = 0;
  int         errCnt = 0;
  logic [2:0] expQ[$];
  vec_t       vecs[$];

  // clock
  always #5 clk = ~clk;

  controller_pipe dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .StallE(StallE), .FlushE(FlushE),
    .FlushM(FlushM), .BranchTakenE(BranchTakenE), .ImmSrcD(ImmSrcD),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .JalrE(JalrE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUSrcAE(ALUSrcAE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .funct3E(funct3E), .IllegalE(IllegalE), .PCSrcE(PCSrcE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .funct3M(funct3M), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
  );

  controller_pipe #(.TRAP_ILLEGAL(0)) dutNoTrap (
    .clk(clk), .reset(reset), .InstrD(InstrD), .StallE(StallE), .FlushE(FlushE),
    .FlushM(FlushM), .BranchTakenE(BranchTakenE), .ImmSrcD(zImmSrcD),
    .RegWriteE(zRegWriteE), .MemWriteE(zMemWriteE), .JumpE(zJumpE), .JalrE(zJalrE),
    .BranchE(zBranchE), .ALUSrcE(zALUSrcE), .ALUSrcAE(zALUSrcAE), .ResultSrcE(zResultSrcE),
    .ALUControlE(zALUControlE), .funct3E(zfunct3E), .IllegalE(zIllegalE), .PCSrcE(zPCSrcE),
    .RegWriteM(zRegWriteM), .MemWriteM(zMemWriteM), .ResultSrcM(zResultSrcM),
    .funct3M(zfunct3M), .RegWriteW(zRegWriteW), .ResultSrcW(zResultSrcW)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    cmpCnt++;
    assert (obs === expv) else begin
      errCnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic stall, input logic fe,
                       input logic fm, input logic rst);
    InstrD = instr;
    StallE = stall;
    FlushE = fe;
    FlushM = fm;
    reset  = rst;
  endtask

  task automatic checkAllZero(input string tag);
    BranchTakenE = 1'b1;
    #1;
    chk({tag, ".RegWriteE"},   RegWriteE,   0);
    chk({tag, ".MemWriteE"},   MemWriteE,   0);
    chk({tag, ".JumpE"},       JumpE,       0);
    chk({tag, ".JalrE"},       JalrE,       0);
    chk({tag, ".BranchE"},     BranchE,     0);
    chk({tag, ".ALUSrcE"},     ALUSrcE,     0);
    chk({tag, ".ALUSrcAE"},    ALUSrcAE,    0);
    chk({tag, ".ResultSrcE"},  ResultSrcE,  0);
    chk({tag, ".ALUControlE"}, ALUControlE, 0);
    chk({tag, ".funct3E"},     funct3E,     0);
    chk({tag, ".IllegalE"},    IllegalE,    0);
    chk({tag, ".PCSrcE"},      PCSrcE,      0);
    chk({tag, ".RegWriteM"},   RegWriteM,   0);
    chk({tag, ".MemWriteM"},   MemWriteM,   0);
    chk({tag, ".ResultSrcM"},  ResultSrcM,  0);
    chk({tag, ".funct3M"},     funct3M,     0);
    chk({tag, ".RegWriteW"},   RegWriteW,   0);
    chk({tag, ".ResultSrcW"},  ResultSrcW,  0);
    BranchTakenE = 1'b0;
  endtask

  initial begin
    int         idx;
    int         lwSeen;
    logic       prevRw;
    logic [2:0] got;
    vec_t       v;

    // instr, rw, mw, aluSrc, aluSrcA, res, alu, chkImm, imm
    vecs.push_back('{32'h003100B3, 1, 0, 0, 0, RES_ALU, ALU_ADD,   0, IMM_I}); // add
    vecs.push_back('{32'h403150B3, 1, 0, 0, 0, RES_ALU, ALU_SRA,   0, IMM_I}); // sra
    vecs.push_back('{32'h403100B3, 1, 0, 0, 0, RES_ALU, ALU_SUB,   0, IMM_I}); // sub
    vecs.push_back('{32'h0031D0B3, 1, 0, 0, 0, RES_ALU, ALU_SRL,   0, IMM_I}); // srl
    vecs.push_back('{32'h003130B3, 1, 0, 0, 0, RES_ALU, ALU_SLTU,  0, IMM_I}); // sltu
    vecs.push_back('{32'h40310093, 1, 0, 1, 0, RES_ALU, ALU_ADD,   1, IMM_I}); // addi, bit30 set
    vecs.push_back('{32'h4030D093, 1, 0, 1, 0, RES_ALU, ALU_SRA,   1, IMM_I}); // srai
    vecs.push_back('{32'h00311093, 1, 0, 1, 0, RES_ALU, ALU_SLL,   1, IMM_I}); // slli
    vecs.push_back('{32'h0FF14093, 1, 0, 1, 0, RES_ALU, ALU_XOR,   1, IMM_I}); // xori
    vecs.push_back('{32'h0000A283, 1, 0, 1, 0, RES_MEM, ALU_ADD,   1, IMM_I}); // lw
    vecs.push_back('{32'h00512023, 0, 1, 1, 0, RES_ALU, ALU_ADD,   1, IMM_S}); // sw
    vecs.push_back('{32'h123450B7, 1, 0, 1, 0, RES_ALU, ALU_PASSB, 1, IMM_U}); // lui
    vecs.push_back('{32'h00001097, 1, 0, 1, 1, RES_ALU, ALU_ADD,   1, IMM_U}); // auipc
    vecs.push_back('{32'h00208463, 0, 0, 0, 0, RES_ALU, ALU_SUB,   1, IMM_B}); // beq

    BranchTakenE = 1'b0;
    drive(32'h003100B3, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkAllZero("reset");
    reset = 1'b0;

    // add: one cycle to E, two to M, three to W
    drive(32'h003100B3, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("add.RegWriteE", RegWriteE, 1);
    chk("add.ALUControlE", ALUControlE, ALU_ADD);
    chk("add.ALUSrcE", ALUSrcE, 0);
    InstrD = 32'h00512023;
    tick();
    chk("add.RegWriteM", RegWriteM, 1);
    tick();
    chk("add.RegWriteW", RegWriteW, 1);
    chk("add.ResultSrcW", ResultSrcW, RES_ALU);

    // random stream, W stage checked through the expected queue
    drive(32'h003100B3, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    reset  = 1'b0;
    prevRw = 1'b0;
    expQ.push_back(3'b000);
    expQ.push_back(3'b000);
    for (int n = 0; n < 30; n++) begin
      idx    = $urandom_range(0, vecs.size() - 1);
      v      = vecs[idx];
      InstrD = v.instr;
      #1;
      if (v.chkImm) chk($sformatf("s%0d.ImmSrcD", n), ImmSrcD, v.imm);
      expQ.push_back({v.rw, v.res});
      tick();
      chk($sformatf("s%0d.RegWriteE", n),   RegWriteE,   v.rw);
      chk($sformatf("s%0d.MemWriteE", n),   MemWriteE,   v.mw);
      chk($sformatf("s%0d.ALUSrcE", n),     ALUSrcE,     v.aluSrc);
      chk($sformatf("s%0d.ALUSrcAE", n),    ALUSrcAE,    v.aluSrcA);
      chk($sformatf("s%0d.ResultSrcE", n),  ResultSrcE,  v.res);
      chk($sformatf("s%0d.ALUControlE", n), ALUControlE, v.alu);
      chk($sformatf("s%0d.PCSrcE", n),      PCSrcE,      0);
      chk($sformatf("s%0d.RegWriteM", n),   RegWriteM,   prevRw);
      prevRw = v.rw;
      got    = expQ.pop_front();
      chk($sformatf("s%0d.Wstage", n), {RegWriteW, ResultSrcW}, got);
    end

    // lw held in E for two cycles: M bubbles, exactly one lw reaches W
    drive(32'h003100B3, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(32'h0000A283, 1'b0, 1'b0, 1'b0, 1'b0);
    lwSeen = 0;
    tick();
    if (ResultSrcW == RES_MEM) lwSeen++;
    chk("lw.ResultSrcE", ResultSrcE, RES_MEM);
    chk("lw.funct3E", funct3E, 3'b010);
    drive(32'h003100B3, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      tick();
      if (ResultSrcW == RES_MEM) lwSeen++;
      chk($sformatf("stall%0d.ResultSrcE", c), ResultSrcE, RES_MEM);
      chk($sformatf("stall%0d.RegWriteM", c), RegWriteM, 0);
    end
    StallE = 1'b0;
    tick();
    if (ResultSrcW == RES_MEM) lwSeen++;
    chk("release.ResultSrcM", ResultSrcM, RES_MEM);
    chk("release.funct3M", funct3M, 3'b010);
    chk("release.ResultSrcE", ResultSrcE, RES_ALU);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (ResultSrcW == RES_MEM) lwSeen++;
    end
    chk("stall.lwCountW", lwSeen, 1);

    // branch compare selection and redirect
    drive(32'h00208463, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("beq.BranchE", BranchE, 1);
    chk("beq.notTaken.PCSrcE", PCSrcE, 0);
    BranchTakenE = 1'b1;
    #1;
    chk("beq.taken.PCSrcE", PCSrcE, 1);
    BranchTakenE = 1'b0;
    InstrD = 32'h00209463;
    tick();
    chk("bne.ALUControlE", ALUControlE, ALU_SUB);
    InstrD = 32'h0020C463;
    tick();
    chk("blt.ALUControlE", ALUControlE, ALU_SLT);
    InstrD = 32'h0020E463;
    tick();
    chk("bltu.ALUControlE", ALUControlE, ALU_SLTU);
    chk("bltu.RegWriteE", RegWriteE, 0);

    // jal / jalr redirect unconditionally and write PC+4
    InstrD = 32'h000000EF;
    #1;
    chk("jal.ImmSrcD", ImmSrcD, IMM_J);
    tick();
    chk("jal.PCSrcE", PCSrcE, 1);
    chk("jal.ResultSrcE", ResultSrcE, RES_PC4);
    chk("jal.JalrE", JalrE, 0);
    InstrD = 32'h000080E7;
    tick();
    chk("jalr.PCSrcE", PCSrcE, 1);
    chk("jalr.JalrE", JalrE, 1);
    chk("jalr.ResultSrcE", ResultSrcE, RES_PC4);

    // illegal encodings
    InstrD = 32'h00000000;
    tick();
    chk("ill0.IllegalE", IllegalE, 1);
    chk("ill0.RegWriteE", RegWriteE, 0);
    chk("ill0.MemWriteE", MemWriteE, 0);
    chk("ill0.noTrap.IllegalE", zIllegalE, 0);
    chk("ill0.noTrap.RegWriteE", zRegWriteE, 0);
    InstrD = 32'h023100B3;
    tick();
    chk("illFunct7.IllegalE", IllegalE, 1);
    chk("illFunct7.RegWriteE", RegWriteE, 0);
    InstrD = 32'h0000B283;
    tick();
    chk("illLoadF3.IllegalE", IllegalE, 1);
    chk("illLoadF3.ResultSrcE", ResultSrcE, 0);
    InstrD = 32'h003100B3;
    tick();
    chk("legal.IllegalE", IllegalE, 0);

    // flush beats stall
    InstrD = 32'h00512023;
    tick();
    chk("sw.MemWriteE", MemWriteE, 1);
    drive(32'h003100B3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("flushStall.MemWriteE", MemWriteE, 0);
    chk("flushStall.RegWriteE", RegWriteE, 0);
    drive(32'h003100B3, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(32'h003100B3, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("flushM.RegWriteM", RegWriteM, 0);
    chk("flushM.RegWriteE", RegWriteE, 1);
    drive(32'h003100B3, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("flushBoth.RegWriteE", RegWriteE, 0);
    chk("flushBoth.RegWriteM", RegWriteM, 0);

    // reset with every stage occupied
    drive(32'h0000A283, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    InstrD = 32'h003100B3;
    tick();
    InstrD = 32'h00512023;
    tick();
    chk("full.MemWriteE", MemWriteE, 1);
    chk("full.RegWriteM", RegWriteM, 1);
    chk("full.ResultSrcW", ResultSrcW, RES_MEM);
    drive(32'h0000A283, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkAllZero("midReset");
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/controller_pipe.md
CONTROLLER_PIPE -- requirements
Module: controller_pipe

Interface
REQ-001 SHALL have parameter ALU_CTRL_W, default 4, width of ALUControl (at least 4).
REQ-002 SHALL have parameter IMM_SRC_W, default 3, width of ImmSrc (at least 3).
REQ-003 SHALL have parameter TRAP_ILLEGAL, default 1; when 1, illegal instructions raise IllegalE; when 0, IllegalE is tied to 0.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 InstrD  in  32  decode-stage instruction.
REQ-007 StallE  in  1  hold the E-stage control register.
REQ-008 FlushE  in  1  load a bubble into E.
REQ-009 FlushM  in  1  load a bubble into M.
REQ-010 BranchTakenE  in  1  branch condition result from the E-stage comparator.
REQ-011 ImmSrcD  out  IMM_SRC_W  combinational immediate select.
REQ-012 E-stage outputs: RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE, ALUSrcAE, ResultSrcE[1:0], ALUControlE[ALU_CTRL_W], funct3E[3], IllegalE, PCSrcE.
REQ-013 M-stage outputs: RegWriteM, MemWriteM, ResultSrcM[1:0], funct3M[3].
REQ-014 W-stage outputs: RegWriteW, ResultSrcW[1:0].

Function
REQ-015 Decode SHALL be combinational from InstrD[6:0], [14:12] and [30], and cover LOAD, STORE, OP, OP-IMM, BRANCH, JAL, JALR, LUI and AUIPC.
REQ-016 ALU ops SHALL be ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA and PASSB.
REQ-017 SUB SHALL be selected only for the OP opcode with funct3=000 and InstrD[30]=1.
REQ-018 SRA SHALL be selected for OP or OP-IMM with funct3=101 and InstrD[30]=1.
REQ-019 LOAD, STORE, JALR and AUIPC SHALL decode to ADD.
REQ-020 LUI SHALL decode to PASSB.
REQ-021 BEQ/BNE SHALL decode to SUB, BLT/BGE to SLT, and BLTU/BGEU to SLTU.
REQ-022 ResultSrc SHALL be 00 for the ALU, 01 for loads, and 10 for PC+4 (JAL/JALR).
REQ-023 ImmSrc SHALL be I=000, S=001, B=010, J=011, U=100.
REQ-024 ALUSrcAE SHALL be 1 only for AUIPC, selecting PC.
REQ-025 ALUSrcE SHALL be 1 for every opcode except OP and BRANCH.
REQ-026 An illegal instruction SHALL decode with all write/jump/branch controls 0 and IllegalE=1 on the next cycle; illegal covers unknown opcodes, undefined funct3 for LOAD/STORE/BRANCH, and funct7 not 0x00/0x20 on OP.
REQ-027 The D-to-E register SHALL have 1-cycle latency; the E-to-M and M-to-W registers SHALL each add 1 cycle.
REQ-028 PCSrcE SHALL equal JumpE | (BranchE & BranchTakenE) and be combinational.
REQ-029 Priority SHALL be reset > FlushE > StallE for the E register.
REQ-030 When StallE=1 and FlushE=0, the E register SHALL hold its value and M SHALL load a bubble, so no duplicate reaches memory.
REQ-031 A bubble SHALL have all fields 0 (RegWrite, MemWrite, Jump, Jalr, Branch and Illegal all 0).
REQ-032 FlushM SHALL bubble M regardless of StallE; the W register SHALL never stall.
REQ-033 FlushE asserted together with FlushM SHALL bubble both stages in the same cycle.

Reset
REQ-034 While reset=1 at a clock edge, the E, M and W registers SHALL all load bubbles.
REQ-035 Reset SHALL force every registered output to 0, including ResultSrc, ALUControl and funct3; PCSrcE SHALL be 0 after reset because it is derived from those registers.
REQ-036 Reset asserted mid-pipeline SHALL discard all in-flight instructions within that one edge.

Structure
REQ-037 Opcode, funct3, ALU op, ImmSrc and ResultSrc encodings SHALL live in riscv_pkg; existing names (OP_RTYPE, ALU_ADD, IMM_I, ...) SHALL be kept, and new ones (OP_JALR, OP_LUI, OP_AUIPC, ALU_XOR, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB, IMM_U) SHALL be added.
REQ-038 A struct typedef ctrl_e_t for the E-stage bundle SHALL be placed in riscv_pkg.
REQ-039 The combinational decode SHALL be a sub-module, main_decoder_ext; the pipeline registers SHALL stay in controller_pipe.

Verification
REQ-040 InstrD=0x003100B3 (add), no stall/flush: cycle+1 RegWriteE=1, ALUControlE=ADD, ALUSrcE=0; cycle+2 RegWriteM=1; cycle+3 RegWriteW=1, ResultSrcW=00.
REQ-041 InstrD=0x403150B3 (sra) -> ALUControlE=SRA; InstrD=0x403100B3 (sub) -> SUB; InstrD=0x40310093 (addi) -> ADD, ALUSrcE=1.
REQ-042 InstrD=0x0000A283 (lw) with StallE=1 for 2 cycles: E holds ResultSrcE=01 for both cycles, M shows bubbles (RegWriteM=0), and a single lw reaches W.
REQ-043 beq in E with BranchTakenE=1 -> PCSrcE=1; with 0 -> PCSrcE=0; InstrD=0x000000EF (jal) -> PCSrcE=1, ResultSrcE=10, ImmSrcD=011.
REQ-044 InstrD=0x00000000 -> IllegalE=1 with RegWriteE=0, MemWriteE=0; with TRAP_ILLEGAL=0 -> IllegalE=0.
REQ-045 sw in E with StallE=1, FlushE=1 and reset=0 -> next-cycle bubble (MemWriteE=0); reset=1 with valid E/M/W contents -> all stage outputs 0 next cycle.
